// File: rtl/muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// muldiv_seq_if
// Purpose : bundles the request/result handshake of the multiply/divide
//           sequencer together with the port set of the shared external
//           carry-select adder that the sequencer drives.
// Modports:
//   slave  - the sequencer (muldiv_seq)
//   master - the pipeline EX stage plus the shared adder
// Signals :
//   start, op, opa, opb   request (op: 0 = multiply, 1 = divide)
//   sgn                   signed request, present only with MULDIV_SIGNED_EN
//   add_a, add_b, add_ci  shared adder operands, driven by the sequencer
//   add_s, add_co         shared adder sum / carry-out
//   busy, done, hi, lo    status and 64-bit result
// ---------------------------------------------------------------------------
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
`ifdef MULDIV_SIGNED_EN
    logic             sgn;
`endif
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_ci;
    logic [WIDTH-1:0] add_s;
    logic             add_co;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport slave (
`ifdef MULDIV_SIGNED_EN
        input  sgn,
`endif
        input  start, op, opa, opb, add_s, add_co,
        output add_a, add_b, add_ci, busy, done, hi, lo
    );

    modport master (
`ifdef MULDIV_SIGNED_EN
        output sgn,
`endif
        output start, op, opa, opb, add_s, add_co,
        input  add_a, add_b, add_ci, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
// Purpose : multi-cycle MULTU/DIVU sequencer for the EX stage. It owns no
//           adder; it issues one add per cycle on the shared external
//           carry-select adder and consumes the sum in the same cycle.
//           Multiply is shift-add, divide is restoring; both take exactly
//           WIDTH CALC cycles. Divide by zero finishes at once with
//           hi = dividend, lo = all ones.
// Ports   :
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - muldiv_seq_if.slave (request, shared adder, busy/done/hi/lo)
// Options :
//   MULDIV_SIGNED_EN - adds bus.sgn and a FIX state that restores the signs
//                      of a signed product / quotient / remainder.
// ---------------------------------------------------------------------------
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
`ifdef MULDIV_SIGNED_EN
        S_FIX  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_mcand;   // multiplicand, or divisor when dividing
    logic             r_op;
    logic [CNT_W-1:0] r_cnt;

    logic             w_div_zero;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_r_sh;    // partial remainder shifted left by one
    logic             w_ok;      // trial subtraction does not go negative

`ifdef MULDIV_SIGNED_EN
    logic             r_sgn;
    logic             r_neg_q;   // negate product / quotient in FIX
    logic             r_neg_r;   // negate remainder in FIX

    assign w_mag_a = (bus.sgn && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
    assign w_mag_b = (bus.sgn && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
`else
    assign w_mag_a = bus.opa;
    assign w_mag_b = bus.opb;
`endif

    assign w_div_zero = bus.op && (bus.opb == '0);
    assign w_r_sh     = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    // A set hi MSB means the shifted remainder exceeds WIDTH bits, so it is
    // certainly larger than the divisor even when the adder carry is clear.
    assign w_ok       = r_hi[WIDTH-1] | bus.add_co;

    assign bus.hi = r_hi;
    assign bus.lo = r_lo;

    // ---- state register ---------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers update from the values present before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---- next-state logic -------------------------------------------------
    // NOTE: each combinational output is given a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = w_div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == CNT_W'(1)) begin
`ifdef MULDIV_SIGNED_EN
                    w_next = r_sgn ? S_FIX : S_DONE;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef MULDIV_SIGNED_EN
            S_FIX:   w_next = S_DONE;
`endif
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---- output logic -----------------------------------------------------
    always_comb begin
        bus.add_a  = '0;
        bus.add_b  = '0;
        bus.add_ci = 1'b0;
        bus.busy   = (r_state != S_IDLE);
        bus.done   = (r_state == S_DONE);
        if (r_state == S_CALC) begin
            if (!r_op) begin
                bus.add_a = r_hi;
                bus.add_b = r_lo[0] ? r_mcand : '0;
            end else begin
                // r_sh - divisor as r_sh + ~divisor + 1
                bus.add_a  = w_r_sh;
                bus.add_b  = ~r_mcand;
                bus.add_ci = 1'b1;
            end
        end
    end

    // ---- datapath ---------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_op    <= 1'b0;
            r_cnt   <= '0;
`ifdef MULDIV_SIGNED_EN
            r_sgn   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op  <= bus.op;
                        r_cnt <= CNT_W'(WIDTH);
`ifdef MULDIV_SIGNED_EN
                        r_sgn   <= bus.sgn;
                        r_neg_q <= bus.sgn & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
                        r_neg_r <= bus.sgn & bus.opa[WIDTH-1];
`endif
                        if (w_div_zero) begin
                            r_hi <= bus.opa;
                            r_lo <= '1;
                        end else if (bus.op) begin
                            r_hi    <= '0;
                            r_lo    <= w_mag_a;
                            r_mcand <= w_mag_b;
                        end else begin
                            r_hi    <= '0;
                            r_lo    <= w_mag_b;
                            r_mcand <= w_mag_a;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (!r_op) begin
                        {r_hi, r_lo} <= {bus.add_co, bus.add_s, r_lo[WIDTH-1:1]};
                    end else begin
                        r_hi <= w_ok ? bus.add_s : w_r_sh;
                        r_lo <= {r_lo[WIDTH-2:0], w_ok};
                    end
                end
`ifdef MULDIV_SIGNED_EN
                S_FIX: begin
                    if (!r_op) begin
                        if (r_neg_q) begin
                            {r_hi, r_lo} <= -{r_hi, r_lo};
                        end
                    end else begin
                        if (r_neg_q) begin
                            r_lo <= -r_lo;
                        end
                        if (r_neg_r) begin
                            r_hi <= -r_hi;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
